wake_power_sequencer: RTL and testbench

- Downstream consumer of the delay_wakeup stage. Once that stage's valid output rises, this block powers up NUM_DOM power domains one at a time, in order 0, 1, and so on.
- For each domain it waits for that domain's power-good acknowledge, then waits a programmable settle time before moving on.
- On sleep request it powers the domains down in reverse order.
- It reports sequence-complete, or a sticky fault together with the index of the failing domain.

---
 rtl/wake_power_sequencer.sv | 159 +++++++++++++++
 tb/tb_wake_power_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wake_power_sequencer.sv
// rtl/wake_power_sequencer.sv - in-order power-domain enable/ack sequencer with reverse-order shutdown
// Brownout on an already-up domain outranks ack/timeout handling of the current one.
module wake_power_sequencer #(
  parameter int NUM_DOM = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wake_valid,
  input  logic               sleep_req,
  input  logic [7:0]         settle_cyc,
  input  logic [NUM_DOM-1:0] dom_ack,
  output logic [NUM_DOM-1:0] dom_en,
  output logic               seq_done,
  output logic               seq_fault,
  output logic [IDX_W-1:0]   fault_idx
);

  typedef enum logic [2:0] {IDLE, WAIT_ACK, SETTLE, DONE, SHUTDOWN, FAULT} state_t;

  localparam logic [IDX_W-1:0] last_idx   = IDX_W'(NUM_DOM - 1);
  localparam logic [7:0]       timer_last = 8'(TIMEOUT - 1);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n, idx_inc, drop_idx, fault_idx_n, fault_at;
  logic [7:0]         timer, timer_n, settle_cnt, settle_n;
  logic [NUM_DOM-1:0] dom_en_n;
  logic               seq_done_n, seq_fault_n, drop_any, fault_go;

  assign idx_inc = idx + 1'b1;

  // Descending scan so the lowest dropped domain is the one reported.
  always_comb begin
    drop_any = 1'b0;
    drop_idx = '0;
    for (int j = NUM_DOM - 1; j >= 0; j--) begin
      if (!dom_ack[j] && ((state == DONE) ||
          ((state == WAIT_ACK || state == SETTLE) && (IDX_W'(j) < idx)))) begin
        drop_any = 1'b1;
        drop_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    timer_n     = timer;
    settle_n    = settle_cnt;
    dom_en_n    = dom_en;
    seq_done_n  = seq_done;
    seq_fault_n = seq_fault;
    fault_idx_n = fault_idx;
    fault_go    = 1'b0;
    fault_at    = '0;

    case (state)
      IDLE: begin
        if (wake_valid && !sleep_req) begin
          dom_en_n = NUM_DOM'(1);
          idx_n    = '0;
          timer_n  = '0;
          state_n  = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (drop_any) begin
          fault_go = 1'b1;
          fault_at = drop_idx;
        end else if (dom_ack[idx]) begin
          settle_n = settle_cyc;
          state_n  = SETTLE;
        end else if (timer == timer_last) begin
          fault_go = 1'b1;
          fault_at = idx;
        end else if (timer != 8'hff) begin
          timer_n = timer + 8'd1;
        end
      end

      SETTLE: begin
        if (drop_any) begin
          fault_go = 1'b1;
          fault_at = drop_idx;
        end else if (settle_cnt == 8'd0) begin
          if (idx == last_idx) begin
            seq_done_n = 1'b1;
            state_n    = DONE;
          end else begin
            idx_n             = idx_inc;
            dom_en_n[idx_inc] = 1'b1;
            timer_n           = '0;
            state_n           = WAIT_ACK;
          end
        end else begin
          settle_n = settle_cnt - 8'd1;
        end
      end

      DONE: begin
        if (drop_any) begin
          fault_go = 1'b1;
          fault_at = drop_idx;
        end else if (sleep_req) begin
          seq_done_n = 1'b0;
          state_n    = SHUTDOWN;
        end
      end

      // idx walks back down from the top domain, one enable per edge.
      SHUTDOWN: begin
        dom_en_n[idx] = 1'b0;
        if (idx == '0) begin
          state_n = IDLE;
        end else begin
          idx_n = idx - 1'b1;
        end
      end

      FAULT: begin
      end

      default: state_n = IDLE;
    endcase

    if (fault_go) begin
      state_n     = FAULT;
      dom_en_n    = '0;
      seq_done_n  = 1'b0;
      seq_fault_n = 1'b1;
      fault_idx_n = fault_at;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      timer      <= '0;
      settle_cnt <= '0;
      dom_en     <= '0;
      seq_done   <= 1'b0;
      seq_fault  <= 1'b0;
      fault_idx  <= '0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      timer      <= timer_n;
      settle_cnt <= settle_n;
      dom_en     <= dom_en_n;
      seq_done   <= seq_done_n;
      seq_fault  <= seq_fault_n;
      fault_idx  <= fault_idx_n;
    end
  end

endmodule

// File: tb/tb_wake_power_sequencer.sv
// tb/tb_wake_power_sequencer.sv - directed bench with a cycle-stamped scoreboard of expected outputs
module tb_wake_power_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wake_valid = 1'b0;
  logic       sleep_req = 1'b0;
  logic [7:0] settle_cyc = 8'd3;
  logic [3:0] dom_ack = 4'b0000;
  logic [3:0] dom_en;
  logic       seq_done;
  logic       seq_fault;
  logic [1:0] fault_idx;

  wake_power_sequencer #(.NUM_DOM(4), .IDX_W(2), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .wake_valid (wake_valid),
    .sleep_req  (sleep_req),
    .settle_cyc (settle_cyc),
    .dom_ack    (dom_ack),
    .dom_en     (dom_en),
    .seq_done   (seq_done),
    .seq_fault  (seq_fault),
    .fault_idx  (fault_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [3:0] en;
    logic       done;
    logic       fault;
    logic [1:0] fidx;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ack_dly[4];
  int         age[4];
  logic [3:0] prev_en = 4'b0000;
  logic [3:0] drop_mask = 4'b0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Domain model: ack rises so that it is sampled ack_dly edges after enable rises (0 = never).
  task automatic apply_ack();
    logic [3:0] a;
    a = 4'b0000;
    for (int i = 0; i < 4; i++)
      a[i] = dom_en[i] && (ack_dly[i] != 0) && (age[i] >= ack_dly[i] - 1) && !drop_mask[i];
    dom_ack = a;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (!dom_en[i] || !prev_en[i]) age[i] = 0;
      else age[i] = age[i] + 1;
    end
    prev_en = dom_en;
    apply_ack();
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      chk("sb_at", 32'(cyc), 32'(e.at));
      chk("sb_en", 32'(dom_en), 32'(e.en));
      chk("sb_done", 32'(seq_done), 32'(e.done));
      chk("sb_fault", 32'(seq_fault), 32'(e.fault));
      chk("sb_fidx", 32'(fault_idx), 32'(e.fidx));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic push(input int at, input logic [3:0] en, input logic done,
                      input logic fault, input logic [1:0] fidx);
    sbq.push_back('{at: at, en: en, done: done, fault: fault, fidx: fidx});
  endtask

  // Power-up schedule from the next edge: enable i+1 follows enable i by ack_dly[i]+1+settle.
  task automatic push_up(input int upto, output int t_last);
    int t;
    t = cyc + 1;
    t_last = t;
    for (int i = 0; i <= upto; i++) begin
      push(t, 4'((1 << (i + 1)) - 1), 1'b0, 1'b0, 2'd0);
      t_last = t;
      t = t + ack_dly[i] + 1 + int'(settle_cyc);
    end
    if (upto == 3) push(t, 4'b1111, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_en"}, 32'(dom_en), 32'd0);
    chk({tag, "_done"}, 32'(seq_done), 32'd0);
    chk({tag, "_fault"}, 32'(seq_fault), 32'd0);
    chk({tag, "_fidx"}, 32'(fault_idx), 32'd0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tl;
    for (int i = 0; i < 4; i++) begin
      ack_dly[i] = 2;
      age[i] = 0;
    end

    run(2);
    chk("rst_en", 32'(dom_en), 32'd0);
    chk("rst_done", 32'(seq_done), 32'd0);
    chk("rst_fault", 32'(seq_fault), 32'd0);
    chk("rst_fidx", 32'(fault_idx), 32'd0);
    rst = 1'b1;
    run(2);
    chk("idle_en", 32'(dom_en), 32'd0);

    // Normal power-up: ack delay 2, settle 3 -> 6-edge spacing.
    wake_valid = 1'b1;
    push_up(3, tl);
    drain(100);

    // Shutdown in reverse order, then restart by dropping sleep_req.
    sleep_req = 1'b1;
    push(cyc + 1, 4'b1111, 1'b0, 1'b0, 2'd0);
    push(cyc + 2, 4'b0111, 1'b0, 1'b0, 2'd0);
    push(cyc + 3, 4'b0011, 1'b0, 1'b0, 2'd0);
    push(cyc + 4, 4'b0001, 1'b0, 1'b0, 2'd0);
    push(cyc + 5, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain(20);
    sleep_req = 1'b0;
    push_up(3, tl);
    drain(100);

    // Brownout: domains 1 and 3 drop together for one edge.
    drop_mask = 4'b1010;
    apply_ack();
    push(cyc + 1, 4'b0000, 1'b0, 1'b1, 2'd1);
    tick();
    drop_mask = 4'b0000;
    drain(2);
    wake_valid = 1'b0;
    reset_pulse("brown_rst");

    // Timeout: domain 2 never acknowledges.
    ack_dly[2] = 0;
    wake_valid = 1'b1;
    push_up(2, tl);
    push(tl + 16, 4'b0000, 1'b0, 1'b1, 2'd2);
    drain(100);
    run(10);
    chk("fault_hold_en", 32'(dom_en), 32'd0);
    chk("fault_hold_flag", 32'(seq_fault), 32'd1);
    chk("fault_hold_idx", 32'(fault_idx), 32'd2);
    wake_valid = 1'b0;
    reset_pulse("to_rst");

    // Boundaries: settle 0, ack on the 16th edge, sleep pulse during WAIT_ACK.
    settle_cyc = 8'd0;
    ack_dly[0] = 1;
    ack_dly[1] = 3;
    ack_dly[2] = 16;
    ack_dly[3] = 2;
    wake_valid = 1'b1;
    push_up(3, tl);
    run(8);
    sleep_req = 1'b1;
    run(2);
    sleep_req = 1'b0;
    drain(100);
    wake_valid = 1'b0;
    reset_pulse("bnd_rst");

    // Asynchronous reset while domain 2 is settling.
    settle_cyc = 8'd5;
    for (int i = 0; i < 4; i++) ack_dly[i] = 2;
    wake_valid = 1'b1;
    push_up(2, tl);
    drain(100);
    run(4);
    chk("mid_settle_en", 32'(dom_en), 32'h7);
    wake_valid = 1'b0;
    reset_pulse("async_rst");
    run(2);
    chk("post_rst_en", 32'(dom_en), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
